// File: rtl/plic_target.sv
// plic_target - target-side core of a PLIC.
//
// Latches rising edges of the gateway request lines as pending bits, picks
// the highest-priority enabled pending source (ties go to the lowest ID),
// raises irq when that priority exceeds the hart threshold, and serves the
// hart's claim/complete handshake.  A valid complete returns a fixed-width
// interrupt_complete pulse to the gateway of the completed source.
//
// Ports:
//   clk, reset_n            clock, asynchronous active-low reset
//   interrupt_request[N]    request pulses from gateways (bit i = ID i+1)
//   priority_in[N*IW]       flat priorities, slice i = priority of ID i+1
//   enable[N]               per-source enable mask
//   threshold[IW]           hart priority threshold
//   claim_req / claim_ack   claim handshake, claim_id valid with claim_ack
//   complete_req/complete_id/complete_ready  complete handshake
//   interrupt_complete[N]   completion pulse per gateway
//   irq                     interrupt to the hart
//
// Optional feature: define PLIC_INSERVICE_MASK_EN to exclude in-service
// sources from arbitration until they are completed.
module plic_target #(
  parameter int Number_of_Sources = 5,
  parameter int Interrupt_Width   = 3,
  parameter int Id_Width          = 3,
  parameter int Complete_Pulse    = 4
) (
  input  logic                                         clk,
  input  logic                                         reset_n,
  input  logic [Number_of_Sources-1:0]                 interrupt_request,
  input  logic [Number_of_Sources*Interrupt_Width-1:0] priority_in,
  input  logic [Number_of_Sources-1:0]                 enable,
  input  logic [Interrupt_Width-1:0]                   threshold,
  input  logic                                         claim_req,
  output logic                                         claim_ack,
  output logic [Id_Width-1:0]                          claim_id,
  input  logic                                         complete_req,
  input  logic [Id_Width-1:0]                          complete_id,
  output logic                                         complete_ready,
  output logic [Number_of_Sources-1:0]                 interrupt_complete,
  output logic                                         irq
);

  localparam int CntW = (Complete_Pulse > 2) ? $clog2(Complete_Pulse) : 1;

  typedef enum logic {C_IDLE, C_PULSE} cstate_t;

  cstate_t                      cstate;
  logic [CntW-1:0]              count;
  logic [Number_of_Sources-1:0] req_q;
  logic [Number_of_Sources-1:0] pending;
  logic [Number_of_Sources-1:0] inservice;
  logic [Id_Width-1:0]          win_id;
  logic [Interrupt_Width-1:0]   win_prio;
  logic                         claim_clr_q;

  logic [Number_of_Sources-1:0] req_edge;
  logic [Number_of_Sources-1:0] cand;
  logic [Number_of_Sources-1:0] claim_sel;
  logic [Number_of_Sources-1:0] cmp_sel;
  logic [Id_Width-1:0]          best_id;
  logic [Interrupt_Width-1:0]   best_prio;
  logic                         arb_valid;
  logic                         claim_take;
  logic                         claim_hit;
  logic                         cmp_fire;

  // win_id/win_prio lag pending by one cycle; after a claim clears a bit
  // they are stale for that cycle, so claims are held off until refreshed.
  assign arb_valid = ~claim_clr_q;

  always_comb begin
    req_edge  = interrupt_request & ~req_q;
    cand      = '0;
    best_id   = '0;
    best_prio = '0;
    claim_sel = '0;
    cmp_sel   = '0;
    for (int unsigned i = 0; i < Number_of_Sources; i++) begin
`ifdef PLIC_INSERVICE_MASK_EN
      cand[i] = pending[i] & enable[i] & ~inservice[i] &
                (priority_in[i*Interrupt_Width +: Interrupt_Width] != '0);
`else
      cand[i] = pending[i] & enable[i] &
                (priority_in[i*Interrupt_Width +: Interrupt_Width] != '0);
`endif
      // Strict '>' keeps the lowest ID on a priority tie.
      if (cand[i] && (priority_in[i*Interrupt_Width +: Interrupt_Width] > best_prio)) begin
        best_prio = priority_in[i*Interrupt_Width +: Interrupt_Width];
        best_id   = Id_Width'(i + 1);
      end
    end
    // Claims during the ack cycle are ignored: the master drops its level
    // request on seeing claim_ack.
    claim_take = claim_req & arb_valid & ~claim_ack;
    claim_hit  = claim_take & (win_prio > threshold);
    for (int unsigned i = 0; i < Number_of_Sources; i++) begin
      claim_sel[i] = claim_hit & (win_id == Id_Width'(i + 1));
      cmp_sel[i]   = (complete_id == Id_Width'(i + 1));
    end
    // cmp_sel is all-zero for ID 0 or out-of-range IDs, which drops them.
    cmp_fire = (cstate == C_IDLE) & complete_req & (|(cmp_sel & inservice));
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      req_q       <= '0;
      pending     <= '0;
      inservice   <= '0;
      win_id      <= '0;
      win_prio    <= '0;
      irq         <= 1'b0;
      claim_ack   <= 1'b0;
      claim_id    <= '0;
      claim_clr_q <= 1'b0;
    end else begin
      req_q       <= interrupt_request;
      // A new request edge wins over a simultaneous claim clear.
      pending     <= (pending & ~claim_sel) | req_edge;
      // Complete sees the pre-claim in-service value.
      inservice   <= (inservice & ~(cmp_fire ? cmp_sel : '0)) | claim_sel;
      win_id      <= best_id;
      win_prio    <= best_prio;
      irq         <= (win_prio > threshold);
      claim_ack   <= claim_take;
      claim_clr_q <= |claim_sel;
      if (claim_take) begin
        claim_id <= claim_hit ? win_id : '0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cstate             <= C_IDLE;
      count              <= '0;
      interrupt_complete <= '0;
      complete_ready     <= 1'b1;
    end else begin
      case (cstate)
        C_IDLE: begin
          if (cmp_fire) begin
            interrupt_complete <= cmp_sel;
            count              <= CntW'(Complete_Pulse - 1);
            complete_ready     <= 1'b0;
            cstate             <= C_PULSE;
          end
        end
        C_PULSE: begin
          if (count == '0) begin
            interrupt_complete <= '0;
            complete_ready     <= 1'b1;
            cstate             <= C_IDLE;
          end else begin
            count <= count - CntW'(1);
          end
        end
      endcase
    end
  end

endmodule
